// File: rtl/mem_arb_pkg.sv
// Shared types for the memory port arbiter.
//   access_size_t : data-port access size encoding (matches d_size)
//   owner_t       : which requester owns the outstanding memory slot
//   pending_t     : per-grant bookkeeping used to shape the next-cycle response
package mem_arb_pkg;

   localparam int MEM_WORDS = 16384;

   typedef enum logic [1:0] {
      SIZE_BYTE    = 2'b00,
      SIZE_HALF    = 2'b01,
      SIZE_WORD    = 2'b10,
      SIZE_ILLEGAL = 2'b11
   } access_size_t;

   typedef enum logic [1:0] {
      OWN_NONE = 2'b00,
      OWN_IF   = 2'b01,
      OWN_D    = 2'b10
   } owner_t;

   typedef struct packed {
      owner_t       owner;
      access_size_t size;
      logic [1:0]   offset;
      logic         is_unsigned;
      logic         is_store;
      logic         err;
   } pending_t;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane alignment for the data port (purely combinational).
// Write side: size/offset -> byte mask, lane-shifted write data, misalign flag.
// Read side : shifts the addressed bytes down, truncates to size and extends.
// Ports:
//   size, offset, we, wdata        : current data request
//   write_mask, lane_wdata         : memory-side write mask and data
//   misaligned                     : illegal size or unaligned half/word
//   rd_size, rd_offset, rd_unsigned: captured attributes of the pending load
//   read_data, load_data           : raw memory word in, aligned result out
module mem_lane_align
   import mem_arb_pkg::*;
(
   input  access_size_t size,
   input  logic [1:0]   offset,
   input  logic         we,
   input  logic [31:0]  wdata,
   output logic [3:0]   write_mask,
   output logic [31:0]  lane_wdata,
   output logic         misaligned,
   input  access_size_t rd_size,
   input  logic [1:0]   rd_offset,
   input  logic         rd_unsigned,
   input  logic [31:0]  read_data,
   output logic [31:0]  load_data
);

   logic [3:0]  base_mask;
   logic [31:0] shifted;

   always_comb begin
      misaligned = 1'b0;
      base_mask  = 4'b0000;
      case (size)
         SIZE_BYTE: base_mask = 4'b0001;
         SIZE_HALF: begin
            base_mask  = 4'b0011;
            misaligned = offset[0];
         end
         SIZE_WORD: begin
            base_mask  = 4'b1111;
            misaligned = (offset != 2'b00);
         end
         default:   misaligned = 1'b1;
      endcase
      // Misaligned accesses never reach the array, so the shifted mask cannot wrap.
      write_mask = (we && !misaligned) ? (base_mask << offset) : 4'b0000;
      lane_wdata = wdata << {offset, 3'b000};
   end

   always_comb begin
      shifted   = read_data >> {rd_offset, 3'b000};
      load_data = 32'h0;
      case (rd_size)
         SIZE_BYTE: load_data = rd_unsigned ? {24'h0, shifted[7:0]}
                                            : {{24{shifted[7]}}, shifted[7:0]};
         SIZE_HALF: load_data = rd_unsigned ? {16'h0, shifted[15:0]}
                                            : {{16{shifted[15]}}, shifted[15:0]};
         SIZE_WORD: load_data = shifted;
         default:   load_data = 32'h0;
      endcase
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-port memory group between instruction fetch and
// load/store. Grants are combinational; responses appear one cycle later.
// Build option: MEM_ARB_ROUND_ROBIN_EN selects round-robin arbitration;
// otherwise data has priority with a fetch starvation override.
// Ports:
//   clk, rst                              : clock, synchronous active-high reset
//   if_req/if_addr -> if_gnt/if_rvalid/if_rdata       : fetch port
//   d_req/d_we/d_addr/d_size/d_unsigned/d_wdata
//      -> d_gnt/d_rvalid/d_rdata/d_err                 : load/store port
//   mem_write_mask/mem_addr/mem_write_data, mem_read_data : memory side
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int STARVE_LIMIT = 4,
   parameter int MEM_ADDR_W   = 14
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  if_req,
   input  logic [MEM_ADDR_W-1:0] if_addr,
   output logic                  if_gnt,
   output logic                  if_rvalid,
   output logic [31:0]           if_rdata,
   input  logic                  d_req,
   input  logic                  d_we,
   input  logic [MEM_ADDR_W+1:0] d_addr,
   input  logic [1:0]            d_size,
   input  logic                  d_unsigned,
   input  logic [31:0]           d_wdata,
   output logic                  d_gnt,
   output logic                  d_rvalid,
   output logic [31:0]           d_rdata,
   output logic                  d_err,
   output logic [3:0]            mem_write_mask,
   output logic [MEM_ADDR_W-1:0] mem_addr,
   output logic [31:0]           mem_write_data,
   input  logic [31:0]           mem_read_data
);

   pending_t    pend, pend_next;
   logic [3:0]  write_mask;
   logic [31:0] lane_wdata;
   logic        misaligned;
   logic [31:0] load_data;

   mem_lane_align u_align (
      .size        (access_size_t'(d_size)),
      .offset      (d_addr[1:0]),
      .we          (d_we),
      .wdata       (d_wdata),
      .write_mask  (write_mask),
      .lane_wdata  (lane_wdata),
      .misaligned  (misaligned),
      .rd_size     (pend.size),
      .rd_offset   (pend.offset),
      .rd_unsigned (pend.is_unsigned),
      .read_data   (mem_read_data),
      .load_data   (load_data)
   );

`ifdef MEM_ARB_ROUND_ROBIN_EN
   logic rr_if_next;

   always_comb begin
      if_gnt = 1'b0;
      d_gnt  = 1'b0;
      if (!rst) begin
         if (if_req && d_req) begin
            if_gnt = rr_if_next;
            d_gnt  = !rr_if_next;
         end else begin
            if_gnt = if_req;
            d_gnt  = d_req;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst)         rr_if_next <= 1'b1;
      else if (if_gnt) rr_if_next <= 1'b0;
      else if (d_gnt)  rr_if_next <= 1'b1;
   end
`else
   logic [3:0] starve_cnt;

   always_comb begin
      if_gnt = 1'b0;
      d_gnt  = 1'b0;
      if (!rst) begin
         if (if_req && (!d_req || starve_cnt == 4'(STARVE_LIMIT))) if_gnt = 1'b1;
         else if (d_req)                                          d_gnt  = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst)                    starve_cnt <= 4'd0;
      else if (if_req && !if_gnt) starve_cnt <= starve_cnt + 4'd1;
      else                        starve_cnt <= 4'd0;
   end
`endif

   always_comb begin
      mem_addr       = '0;
      mem_write_mask = 4'b0000;
      mem_write_data = 32'h0;
      if (if_gnt) begin
         mem_addr = if_addr;
      end else if (d_gnt) begin
         mem_addr       = d_addr[MEM_ADDR_W+1:2];
         mem_write_mask = write_mask;
         mem_write_data = lane_wdata;
      end
   end

   always_comb begin
      pend_next.owner       = if_gnt ? OWN_IF : (d_gnt ? OWN_D : OWN_NONE);
      pend_next.size        = access_size_t'(d_size);
      pend_next.offset      = d_addr[1:0];
      pend_next.is_unsigned = d_unsigned;
      pend_next.is_store    = d_we;
      pend_next.err         = d_gnt && misaligned;
   end

   always_ff @(posedge clk) begin
      if (rst) pend <= '0;
      else     pend <= pend_next;
   end

   // Gating on rst drops a response whose grant was followed by reset.
   always_comb begin
      if_rvalid = !rst && (pend.owner == OWN_IF);
      d_rvalid  = !rst && (pend.owner == OWN_D);
      if_rdata  = if_rvalid ? mem_read_data : 32'h0;
      d_err     = d_rvalid && pend.err;
      d_rdata   = (d_rvalid && !pend.err && !pend.is_store) ? load_data : 32'h0;
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req;
   logic [13:0] if_addr;
   logic        if_gnt, if_rvalid;
   logic [31:0] if_rdata;
   logic        d_req, d_we, d_unsigned;
   logic [15:0] d_addr;
   logic [1:0]  d_size;
   logic [31:0] d_wdata;
   logic        d_gnt, d_rvalid, d_err;
   logic [31:0] d_rdata;
   logic [3:0]  mem_write_mask;
   logic [13:0] mem_addr;
   logic [31:0] mem_write_data;
   logic [31:0] mem_read_data;

   logic [31:0] mem [0:16383];

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   mem_port_arbiter #(.STARVE_LIMIT(4), .MEM_ADDR_W(14)) dut (
      .clk            (clk),
      .rst            (rst),
      .if_req         (if_req),
      .if_addr        (if_addr),
      .if_gnt         (if_gnt),
      .if_rvalid      (if_rvalid),
      .if_rdata       (if_rdata),
      .d_req          (d_req),
      .d_we           (d_we),
      .d_addr         (d_addr),
      .d_size         (d_size),
      .d_unsigned     (d_unsigned),
      .d_wdata        (d_wdata),
      .d_gnt          (d_gnt),
      .d_rvalid       (d_rvalid),
      .d_rdata        (d_rdata),
      .d_err          (d_err),
      .mem_write_mask (mem_write_mask),
      .mem_addr       (mem_addr),
      .mem_write_data (mem_write_data),
      .mem_read_data  (mem_read_data)
   );

   // Registered single-port memory, read-before-write, one cycle latency.
   always @(posedge clk) begin
      mem_read_data <= mem[mem_addr];
      for (int b = 0; b < 4; b++)
         if (mem_write_mask[b]) mem[mem_addr][8*b +: 8] <= mem_write_data[8*b +: 8];
   end

   // One data-port transaction starting at a negedge; returns what was observed
   // in the grant cycle and in the response cycle.
   task automatic d_xfer(input logic we, input logic [15:0] addr, input logic [1:0] size,
                         input logic uns, input logic [31:0] wdata,
                         output logic gnt, output logic igt, output logic [3:0] mask,
                         output logic [13:0] maddr, output logic [31:0] mwdata,
                         output logic rv, output logic [31:0] rd, output logic er);
      d_req = 1'b1; d_we = we; d_addr = addr; d_size = size; d_unsigned = uns; d_wdata = wdata;
      #1;
      gnt = d_gnt; igt = if_gnt; mask = mem_write_mask; maddr = mem_addr; mwdata = mem_write_data;
      @(posedge clk);
      @(negedge clk);
      d_req = 1'b0; if_req = 1'b0;
      #1;
      rv = d_rvalid; rd = d_rdata; er = d_err;
      @(negedge clk);
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; if_req = 1'b1; if_addr = 14'd7; d_req = 1'b1; d_we = 1'b1;
      d_addr = 16'h0004; d_size = 2'b10; d_unsigned = 1'b0; d_wdata = 32'hffff_ffff;
      repeat (2) @(negedge clk);
      #1;
      n_tests++;
      if ({if_gnt, d_gnt, if_rvalid, d_rvalid, d_err} !== 5'b0) begin
         n_fail++;
         $display("FAIL reset_ctrl: got %b required 00000", {if_gnt, d_gnt, if_rvalid, d_rvalid, d_err});
      end
      n_tests++;
      if (mem_write_mask !== 4'h0 || mem_addr !== 14'd0 || if_rdata !== 32'h0 || d_rdata !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_mem: mask=%h addr=%h if_rdata=%h d_rdata=%h required all 0",
                  mem_write_mask, mem_addr, if_rdata, d_rdata);
      end
      if_req = 1'b0; d_req = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_store_load_word();
      logic gnt, igt, rv, er; logic [3:0] mask; logic [13:0] ma; logic [31:0] mw, rd;
      d_xfer(1'b1, 16'h0000, 2'b10, 1'b0, 32'h77ff8855, gnt, igt, mask, ma, mw, rv, rd, er);
      n_tests++;
      if (gnt !== 1'b1 || mask !== 4'b1111 || ma !== 14'd0 || mw !== 32'h77ff8855) begin
         n_fail++;
         $display("FAIL store_word: gnt=%b mask=%b addr=%h wdata=%h required 1 1111 0 77ff8855", gnt, mask, ma, mw);
      end
      n_tests++;
      if (rv !== 1'b1 || er !== 1'b0 || rd !== 32'h0) begin
         n_fail++;
         $display("FAIL store_resp: rvalid=%b err=%b rdata=%h required 1 0 00000000", rv, er, rd);
      end
      d_xfer(1'b0, 16'h0000, 2'b10, 1'b0, 32'h0, gnt, igt, mask, ma, mw, rv, rd, er);
      n_tests++;
      if (gnt !== 1'b1 || mask !== 4'b0000 || rv !== 1'b1 || er !== 1'b0 || rd !== 32'h77ff8855) begin
         n_fail++;
         $display("FAIL load_word: gnt=%b mask=%b rvalid=%b err=%b rdata=%h required 1 0000 1 0 77ff8855",
                  gnt, mask, rv, er, rd);
      end
   endtask

   task automatic test_subword_loads();
      logic gnt, igt, rv, er; logic [3:0] mask; logic [13:0] ma; logic [31:0] mw, rd;
      logic [15:0] a   [4] = '{16'h0002, 16'h0002, 16'h0002, 16'h0000};
      logic [1:0]  sz  [4] = '{2'b00, 2'b00, 2'b01, 2'b01};
      logic        un  [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
      logic [31:0] exp [4] = '{32'hffffffff, 32'h000000ff, 32'h000077ff, 32'hffff8855};
      for (int i = 0; i < 4; i++) begin
         d_xfer(1'b0, a[i], sz[i], un[i], 32'h0, gnt, igt, mask, ma, mw, rv, rd, er);
         n_tests++;
         if (rv !== 1'b1 || er !== 1'b0 || rd !== exp[i]) begin
            n_fail++;
            $display("FAIL subword_load[%0d]: rvalid=%b err=%b rdata=%h required 1 0 %h", i, rv, er, rd, exp[i]);
         end
      end
   endtask

   task automatic test_byte_store();
      logic gnt, igt, rv, er; logic [3:0] mask; logic [13:0] ma; logic [31:0] mw, rd;
      d_xfer(1'b1, 16'h0004, 2'b10, 1'b0, 32'h0, gnt, igt, mask, ma, mw, rv, rd, er);
      d_xfer(1'b1, 16'h0005, 2'b00, 1'b0, 32'h000000ab, gnt, igt, mask, ma, mw, rv, rd, er);
      n_tests++;
      if (gnt !== 1'b1 || ma !== 14'd1 || mask !== 4'b0010 || mw !== 32'h0000ab00) begin
         n_fail++;
         $display("FAIL byte_store: gnt=%b addr=%h mask=%b wdata=%h required 1 1 0010 0000ab00", gnt, ma, mask, mw);
      end
      d_xfer(1'b0, 16'h0004, 2'b10, 1'b0, 32'h0, gnt, igt, mask, ma, mw, rv, rd, er);
      n_tests++;
      if (rv !== 1'b1 || rd !== 32'h0000ab00) begin
         n_fail++;
         $display("FAIL byte_store_readback: rvalid=%b rdata=%h required 1 0000ab00", rv, rd);
      end
      d_xfer(1'b1, 16'h0006, 2'b01, 1'b0, 32'h0000c3d4, gnt, igt, mask, ma, mw, rv, rd, er);
      n_tests++;
      if (mask !== 4'b1100 || mw !== 32'hc3d40000) begin
         n_fail++;
         $display("FAIL half_store_hi: mask=%b wdata=%h required 1100 c3d40000", mask, mw);
      end
   endtask

   task automatic test_misaligned();
      logic gnt, igt, rv, er; logic [3:0] mask; logic [13:0] ma; logic [31:0] mw, rd;
      if_req = 1'b1; if_addr = 14'd2;
      d_xfer(1'b0, 16'h0006, 2'b10, 1'b0, 32'h0, gnt, igt, mask, ma, mw, rv, rd, er);
      n_tests++;
      if (gnt !== 1'b1 || igt !== 1'b0 || mask !== 4'b0000) begin
         n_fail++;
         $display("FAIL misalign_gnt: d_gnt=%b if_gnt=%b mask=%b required 1 0 0000", gnt, igt, mask);
      end
      n_tests++;
      if (rv !== 1'b1 || er !== 1'b1 || rd !== 32'h0) begin
         n_fail++;
         $display("FAIL misalign_resp: rvalid=%b err=%b rdata=%h required 1 1 00000000", rv, er, rd);
      end
      d_xfer(1'b1, 16'h0000, 2'b11, 1'b0, 32'h12345678, gnt, igt, mask, ma, mw, rv, rd, er);
      n_tests++;
      if (gnt !== 1'b1 || mask !== 4'b0000 || rv !== 1'b1 || er !== 1'b1 || rd !== 32'h0) begin
         n_fail++;
         $display("FAIL illegal_size: gnt=%b mask=%b rvalid=%b err=%b rdata=%h required 1 0000 1 1 0",
                  gnt, mask, rv, er, rd);
      end
      d_xfer(1'b0, 16'h0001, 2'b01, 1'b0, 32'h0, gnt, igt, mask, ma, mw, rv, rd, er);
      n_tests++;
      if (gnt !== 1'b1 || rv !== 1'b1 || er !== 1'b1 || rd !== 32'h0) begin
         n_fail++;
         $display("FAIL odd_half: gnt=%b rvalid=%b err=%b rdata=%h required 1 1 1 0", gnt, rv, er, rd);
      end
   endtask

   task automatic test_contention();
`ifdef MEM_ARB_ROUND_ROBIN_EN
      logic exp_if [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
`else
      logic exp_if [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
`endif
      apply_reset();
      if_req = 1'b1; if_addr = 14'd0;
      d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0000; d_size = 2'b10; d_unsigned = 1'b0;
      for (int k = 0; k < 7; k++) begin
         #1;
         n_tests++;
         if (if_gnt !== exp_if[k] || d_gnt !== !exp_if[k]) begin
            n_fail++;
            $display("FAIL contention_gnt[%0d]: if_gnt=%b d_gnt=%b required %b %b",
                     k, if_gnt, d_gnt, exp_if[k], !exp_if[k]);
         end
         if (k > 0) begin
            n_tests++;
            if (if_rvalid !== exp_if[k-1] || d_rvalid !== !exp_if[k-1] ||
                (exp_if[k-1] && if_rdata !== 32'h77ff8855)) begin
               n_fail++;
               $display("FAIL contention_resp[%0d]: if_rvalid=%b d_rvalid=%b if_rdata=%h required %b %b",
                        k, if_rvalid, d_rvalid, if_rdata, exp_if[k-1], !exp_if[k-1]);
            end
         end
         @(negedge clk);
      end
      if_req = 1'b0; d_req = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset_midop();
      logic gnt, igt, rv, er; logic [3:0] mask; logic [13:0] ma; logic [31:0] mw, rd;
      d_xfer(1'b1, 16'h000c, 2'b10, 1'b0, 32'h0badcafe, gnt, igt, mask, ma, mw, rv, rd, er);
      if_req = 1'b1; if_addr = 14'd3;
      #1;
      n_tests++;
      if (if_gnt !== 1'b1 || mem_addr !== 14'd3) begin
         n_fail++;
         $display("FAIL midop_first_gnt: if_gnt=%b addr=%h required 1 3", if_gnt, mem_addr);
      end
      @(negedge clk);
      rst = 1'b1;
      #1;
      n_tests++;
      if (if_rvalid !== 1'b0 || if_gnt !== 1'b0 || mem_addr !== 14'd0 || if_rdata !== 32'h0 ||
          d_rvalid !== 1'b0 || mem_write_mask !== 4'h0) begin
         n_fail++;
         $display("FAIL midop_reset: if_rvalid=%b if_gnt=%b addr=%h if_rdata=%h required 0 0 0 0",
                  if_rvalid, if_gnt, mem_addr, if_rdata);
      end
      @(negedge clk);
      rst = 1'b0;
      #1;
      n_tests++;
      if (if_rvalid !== 1'b0 || if_gnt !== 1'b1 || mem_addr !== 14'd3) begin
         n_fail++;
         $display("FAIL midop_regrant: if_rvalid=%b if_gnt=%b addr=%h required 0 1 3", if_rvalid, if_gnt, mem_addr);
      end
      @(negedge clk);
      if_req = 1'b0;
      #1;
      n_tests++;
      if (if_rvalid !== 1'b1 || if_rdata !== 32'h0badcafe) begin
         n_fail++;
         $display("FAIL midop_resp: if_rvalid=%b if_rdata=%h required 1 0badcafe", if_rvalid, if_rdata);
      end
      @(negedge clk);
      #1;
      n_tests++;
      if (if_rvalid !== 1'b0 || d_rvalid !== 1'b0) begin
         n_fail++;
         $display("FAIL idle_no_resp: if_rvalid=%b d_rvalid=%b required 0 0", if_rvalid, d_rvalid);
      end
   endtask

   initial begin
      test_reset();
      test_store_load_word();
      test_subword_loads();
      test_byte_store();
      test_misaligned();
      test_contention();
      test_reset_midop();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
